fix_point_multiplier: RTL

FIX_POINT_MULTIPLIER -- requirements
Module: fix_point_multiplier

---
 rtl/fix_point_multiplier.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fix_point_multiplier.sv
// Sequential sign-magnitude Q-format multiplier: one shift-add step per cycle over the
// magnitude bits of b, then truncate by Q, saturate and apply the sign.
module fix_point_multiplier #(
  parameter int unsigned Q = 13,
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         poke,
  output logic [N-1:0] product,
  output logic         peek,
  output logic         busy,
  output logic         overflow
);

  localparam int unsigned MagW = N - 1;
  localparam int unsigned AccW = 2 * (N - 1);
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]      product_q, product_d;
  logic              peek_q, peek_d;
  logic              ovf_q, ovf_d;

  logic [AccW-1:0]   a_ext;
  logic [AccW-1:0]   shifted;
  logic              sat;
  logic [MagW-1:0]   res_mag;
  logic              res_sign;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (poke) state_d = StCalc;
      StCalc: if (cnt_q == CntW'(N - 2)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign a_ext    = {{(AccW - MagW){1'b0}}, a_q[MagW-1:0]};
  assign shifted  = acc_q >> Q;
  assign sat      = |shifted[AccW-1:MagW];
  assign res_mag  = sat ? {MagW{1'b1}} : shifted[MagW-1:0];
  // A zero magnitude never carries a negative sign.
  assign res_sign = (a_q[N-1] ^ b_q[N-1]) & (|res_mag);

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    peek_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (poke) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      StCalc: begin
        if (b_q[cnt_q]) acc_d = acc_q + (a_ext << cnt_q);
        cnt_d = cnt_q + CntW'(1);
      end
      StDone: begin
        product_d = {res_sign, res_mag};
        ovf_d     = sat;
        peek_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      peek_q    <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      peek_q    <= peek_d;
    end
  end

  // Outputs
  always_comb begin
    busy     = (state_q != StIdle);
    product  = product_q;
    peek     = peek_q;
    overflow = ovf_q;
  end

endmodule
